// File: rtl/p_mem_ctrl_if.sv
// Bundle of the IF/MEM request buses and the byte-wide RAM port of p_mem_ctrl.
interface p_mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic        busy_out;

  // Controller side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy_out
  );

  // Pipeline stages and RAM side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy_out
  );
endinterface

// File: rtl/p_mem_ctrl.sv
// Byte-serial RAM controller arbitrating IF and MEM (MEM has priority),
// sequencing 1/2/4-byte little-endian reads and writes one byte per cycle.
module p_mem_ctrl #(
  parameter int unsigned RAM_LAT = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  p_mem_ctrl_if.slave  bus
);

  localparam logic [2:0] LAT = 3'(RAM_LAT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t      state_q;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  n_q;
  logic [2:0]  cnt_q;
  logic [31:0] ram_a_q;
  logic        ram_wr_q;
  logic [7:0]  ram_dout_q;
  logic        if_done_q;
  logic        mem_done_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic        busy_q;

  logic [2:0]  mem_n_d;
  logic [1:0]  lane_d;

  // Byte count of a MEM request; width 11 is treated as a word.
  always_comb begin
    case (bus.mem_width)
      2'b00:   mem_n_d = 3'd1;
      2'b01:   mem_n_d = 3'd2;
      default: mem_n_d = 3'd4;
    endcase
  end

  // cnt_q counts edges since grant; the byte arriving now was addressed LAT edges ago.
  always_comb lane_d = 2'(cnt_q - LAT);

  // Arbitration, byte sequencing and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Byte 0 is issued on the grant edge itself.
          if (bus.mem_req) begin
            owner_q     <= OWN_MEM;
            addr_q      <= bus.mem_addr;
            wdata_q     <= bus.mem_wdata;
            n_q         <= mem_n_d;
            cnt_q       <= 3'd1;
            mem_rdata_q <= '0;
            ram_a_q     <= bus.mem_addr;
            ram_wr_q    <= bus.mem_we;
            if (bus.mem_we) ram_dout_q <= bus.mem_wdata[7:0];
            busy_q      <= 1'b1;
            state_q     <= bus.mem_we ? WRITE : READ;
          end else if (bus.if_req) begin
            owner_q   <= OWN_IF;
            addr_q    <= bus.if_addr;
            wdata_q   <= '0;
            n_q       <= 3'd4;
            cnt_q     <= 3'd1;
            if_data_q <= '0;
            ram_a_q   <= bus.if_addr;
            ram_wr_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= READ;
          end
        end

        READ: begin
          if (cnt_q < n_q) ram_a_q <= addr_q + {29'b0, cnt_q};
          if (cnt_q >= LAT) begin
            if (owner_q == OWN_MEM) mem_rdata_q[{lane_d, 3'b000} +: 8] <= bus.ram_din;
            else                    if_data_q[{lane_d, 3'b000} +: 8]   <= bus.ram_din;
          end
          if (cnt_q == n_q + LAT - 3'd1) begin
            state_q <= DONE;
            if (owner_q == OWN_MEM) mem_done_q <= 1'b1;
            else                    if_done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        WRITE: begin
          if (cnt_q < n_q) begin
            ram_a_q    <= addr_q + {29'b0, cnt_q};
            ram_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            ram_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end else begin
            ram_wr_q <= 1'b0;
            state_q  <= DONE;
            if (owner_q == OWN_MEM) mem_done_q <= 1'b1;
            else                    if_done_q  <= 1'b1;
          end
        end

        default: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_p_mem_ctrl.sv
// Randomized bench for p_mem_ctrl against a byte-array RAM model.
module tb_p_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  p_mem_ctrl_if bus ();

  p_mem_ctrl #(.RAM_LAT(2)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];
  logic [31:0] a_prev = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // RAM: writes commit on the edge after they are registered; read data
  // appears so that it is sampled two edges after its address was registered.
  always @(negedge clk) begin
    if (bus.ram_wr === 1'b1) begin
      mem[bus.ram_a] = bus.ram_dout;
      wa_q.push_back(bus.ram_a);
      wd_q.push_back(bus.ram_dout);
    end
    bus.ram_din = rd(a_prev);
    a_prev = bus.ram_a;
  end

  task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned n;
    int unsigned lim;
    logic [31:0] exp_data;
    bit seen;
    n = is_mem ? nbytes(width) : 4;
    lim = (is_mem && we) ? n + 1 : n + 2;
    exp_data = '0;
    for (int unsigned i = 0; i < n; i++) exp_data |= 32'(rd(addr + i)) << (8 * i);
    wa_q.delete();
    wd_q.delete();
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_width = width;
      bus.mem_addr = addr; bus.mem_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    seen = 1'b0;
    for (int unsigned c = 1; c <= 16 && !seen; c++) begin
      @(posedge clk); #1;
      if (c <= n) begin
        check_eq("ram_a", bus.ram_a, addr + (c - 1));
        check_eq("ram_wr", 32'(bus.ram_wr), 32'(is_mem && we));
      end
      if ((is_mem ? bus.mem_done : bus.if_done) === 1'b1) begin
        seen = 1'b1;
        bus.mem_req = 1'b0;
        bus.if_req = 1'b0;
        check_eq("done_latency", c, lim);
        check_eq("other_done", 32'(is_mem ? bus.if_done : bus.mem_done), 0);
        check_eq("busy_in_done", 32'(bus.busy_out), 1);
        if (!(is_mem && we)) check_eq(is_mem ? "mem_rdata" : "if_data",
                                      is_mem ? bus.mem_rdata : bus.if_data, exp_data);
        else check_eq("ram_wr_at_done", 32'(bus.ram_wr), 0);
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
      bus.mem_req = 1'b0;
      bus.if_req = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("done_pulse_len", 32'({bus.if_done, bus.mem_done}), 0);
    check_eq("busy_after", 32'(bus.busy_out), 0);
    if (is_mem && we) begin
      check_eq("write_count", wa_q.size(), n);
      for (int unsigned i = 0; i < n && i < wa_q.size(); i++) begin
        check_eq("write_addr", wa_q[i], addr + i);
        check_eq("write_byte", 32'(wd_q[i]), 32'((wdata >> (8 * i)) & 32'hFF));
      end
    end else begin
      check_eq("read_no_write", wa_q.size(), 0);
    end
  endtask

  initial begin
    int unsigned mc;
    int unsigned ic;
    logic [31:0] a;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_width = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.ram_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    for (int unsigned c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_eq("idle_ram_a", bus.ram_a, 0);
      check_eq("idle_ctrl", 32'({bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done, bus.busy_out}), 0);
      check_eq("idle_data", bus.if_data | bus.mem_rdata, 0);
    end

    // IF word read.
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
    run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
    check_eq("if_word_const", bus.if_data, 32'h00100513);

    // MEM half store across a 0x2000 boundary.
    run_txn(1'b1, 1'b1, 2'b01, 32'h1FFF, 32'hAABBCCDD);
    check_eq("half_b0", 32'(rd(32'h1FFF)), 32'hDD);
    check_eq("half_b1", 32'(rd(32'h2000)), 32'hCC);

    // Simultaneous requests: MEM byte load first, then IF word read.
    mem[32'h40] = 8'hF0;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = 2'b00; bus.mem_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    mc = 0; ic = 0;
    for (int unsigned c = 1; c <= 20 && ic == 0; c++) begin
      @(posedge clk); #1;
      check_eq("dones_exclusive", 32'(bus.if_done & bus.mem_done), 0);
      if (bus.mem_done === 1'b1) begin
        mc = c;
        bus.mem_req = 1'b0;
        check_eq("prio_mem_rdata", bus.mem_rdata, 32'h000000F0);
      end
      if (bus.if_done === 1'b1) begin
        ic = c;
        bus.if_req = 1'b0;
        check_eq("prio_if_data", bus.if_data,
                 {rd(32'h203), rd(32'h202), rd(32'h201), rd(32'h200)});
      end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    check_eq("prio_mem_cycle", mc, 3);
    check_eq("prio_if_cycle", ic, 10);
    @(posedge clk); #1;

    // Back-to-back MEM word loads with the request held.
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = 2'b10; bus.mem_addr = 32'h3000;
    mc = 0; ic = 0;
    for (int unsigned c = 1; c <= 25 && ic == 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_done === 1'b1) begin
        if (mc == 0) begin
          mc = c;
          check_eq("b2b_data0", bus.mem_rdata,
                   {rd(32'h3003), rd(32'h3002), rd(32'h3001), rd(32'h3000)});
          bus.mem_addr = 32'h3010;
        end else begin
          ic = c;
          bus.mem_req = 1'b0;
          check_eq("b2b_data1", bus.mem_rdata,
                   {rd(32'h3013), rd(32'h3012), rd(32'h3011), rd(32'h3010)});
        end
      end
    end
    bus.mem_req = 1'b0;
    check_eq("b2b_first_done", mc, 6);
    check_eq("b2b_second_done", ic, 13);
    mc = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.mem_done !== 1'b0 || (c > 0 && bus.busy_out !== 1'b0)) mc++;
    end
    check_eq("b2b_no_third", mc, 0);

    // Reset during the third byte of a word store.
    wa_q.delete(); wd_q.delete();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = 2'b10;
    bus.mem_addr = 32'h5000; bus.mem_wdata = 32'h44332211;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_ram_wr", 32'(bus.ram_wr), 0);
    check_eq("rst_busy", 32'(bus.busy_out), 0);
    rst = 1'b0; bus.mem_req = 1'b0;
    mc = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.mem_done !== 1'b0) mc++;
    end
    check_eq("rst_no_done", mc, 0);
    check_eq("rst_write_count", wa_q.size(), 2);
    check_eq("rst_b1", 32'(rd(32'h5001)), 32'h22);
    check_eq("rst_b2_untouched", 32'(rd(32'h5002)), 32'(8'h50 ^ 8'h02 ^ 8'h5A));
    run_txn(1'b0, 1'b0, 2'b10, 32'h5000, 32'h0);

    // Randomized mix, including 32-bit address wrap.
    for (int unsigned t = 0; t < 40; t++) begin
      bit is_mem;
      bit we;
      logic [1:0] w;
      is_mem = 1'($urandom_range(0, 1));
      we = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      w = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      run_txn(is_mem, we, w, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
